// File: rtl/aidan_mcnay_prime_engine.sv
// Stream-interfaced trial-division prime engine: divisor 2 then odd divisors,
// each tested with a bit-serial restoring remainder, stopping once d*d > n.
module aidan_mcnay_prime_engine #(
    parameter int unsigned nbits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [nbits-1:0] in_num,
    output logic             out_val,
    input  logic             out_rdy,
    output logic             is_prime,
    output logic [nbits-1:0] factor,
    output logic [nbits-1:0] iters
);

    localparam int unsigned BW = $clog2(nbits);
    localparam int unsigned DW = nbits + 2;

    localparam logic [BW-1:0]    LastBit = BW'(nbits - 1);
    localparam logic [BW-1:0]    BitOne  = BW'(1);
    localparam logic [nbits-1:0] NumOne  = nbits'(1);
    localparam logic [nbits-1:0] NumTwo  = nbits'(2);
    localparam logic [nbits-1:0] NumThr  = nbits'(3);
    localparam logic [nbits-1:0] NumFour = nbits'(4);
    localparam logic [DW-1:0]    SqFour  = DW'(4);
    localparam logic [DW-1:0]    SqNine  = DW'(9);

    typedef enum logic [2:0] {StIdle, StCheck, StDiv, StTest, StDone} state_e;

    state_e           state_q;
    logic [nbits-1:0] n_q;
    logic [nbits-1:0] d_q;
    logic [DW-1:0]    dsq_q;
    logic [nbits:0]   rem_q;
    logic [BW-1:0]    bitcnt_q;
    logic             is_prime_q;
    logic [nbits-1:0] factor_q;
    logic [nbits-1:0] iters_q;

    logic [BW-1:0]    bit_idx;
    logic [nbits:0]   rem_t;
    logic [nbits:0]   rem_step;
    logic [nbits-1:0] d_next;
    logic [DW-1:0]    dsq_next;
    logic [nbits-1:0] iters_sat;

    always_comb begin
        bit_idx  = LastBit - bitcnt_q;
        rem_t    = {rem_q[nbits-1:0], n_q[bit_idx]};
        rem_step = (rem_t >= {1'b0, d_q}) ? rem_t - {1'b0, d_q} : rem_t;
        // (d+2)^2 = d^2 + 4d + 4, kept incremental to avoid a multiplier
        if (d_q == NumTwo) begin
            d_next   = NumThr;
            dsq_next = SqNine;
        end else begin
            d_next   = d_q + NumTwo;
            dsq_next = dsq_q + {d_q, 2'b00} + SqFour;
        end
        iters_sat = (iters_q == '1) ? iters_q : iters_q + NumOne;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            n_q        <= '0;
            d_q        <= '0;
            dsq_q      <= '0;
            rem_q      <= '0;
            bitcnt_q   <= '0;
            is_prime_q <= 1'b0;
            factor_q   <= '0;
            iters_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_val) begin
                        n_q     <= in_num;
                        iters_q <= '0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (n_q < NumTwo) begin
                        is_prime_q <= 1'b0;
                        factor_q   <= '0;
                        state_q    <= StDone;
                    end else if (n_q < NumFour) begin
                        is_prime_q <= 1'b1;
                        factor_q   <= n_q;
                        state_q    <= StDone;
                    end else begin
                        d_q      <= NumTwo;
                        dsq_q    <= SqFour;
                        rem_q    <= '0;
                        bitcnt_q <= '0;
                        state_q  <= StDiv;
                    end
                end
                StDiv: begin
                    rem_q    <= rem_step;
                    bitcnt_q <= bitcnt_q + BitOne;
                    if (bitcnt_q == LastBit) begin
                        state_q <= StTest;
                    end
                end
                StTest: begin
                    iters_q <= iters_sat;
                    if (rem_q == '0) begin
                        is_prime_q <= 1'b0;
                        factor_q   <= d_q;
                        state_q    <= StDone;
                    end else begin
                        d_q   <= d_next;
                        dsq_q <= dsq_next;
                        if (dsq_next > {2'b00, n_q}) begin
                            is_prime_q <= 1'b1;
                            factor_q   <= n_q;
                            state_q    <= StDone;
                        end else begin
                            rem_q    <= '0;
                            bitcnt_q <= '0;
                            state_q  <= StDiv;
                        end
                    end
                end
                StDone: begin
                    if (out_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_rdy   = (state_q == StIdle);
    assign out_val  = (state_q == StDone);
    assign is_prime = is_prime_q;
    assign factor   = factor_q;
    assign iters    = iters_q;

endmodule

// File: doc/aidan_mcnay_prime_engine.md
Name: aidan_mcnay_prime_engine

Overview:
- Parametrised, stream-interfaced successor to the top-level prime detector.
- Accepts one nbits candidate per valid/ready transaction and runs trial division internally with a bit-serial restoring remainder unit.
- Tries divisor 2, then odd divisors only, and stops early once d*d > n.
- Returns is_prime, the smallest factor and the number of divisors tried. Sits behind the SIPO/CS front end, replacing the separate counter, divider and FSM.

Parameters:
- nbits, 32: candidate width. Must be even and >= 4.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  candidate valid
- in_rdy  output  1  engine idle and able to accept a candidate
- in_num  input  nbits  candidate n, unsigned
- out_val  output  1  result valid
- out_rdy  input  1  consumer accepts result
- is_prime  output  1  1 if n is prime
- factor  output  nbits  smallest factor >= 2. Equals n if n is prime; 0 if n < 2.
- iters  output  nbits  number of divisors tested (DIV passes completed)

Behaviour:
- Reset: state=IDLE. in_rdy=1, out_val=0, is_prime=0, factor=0, iters=0. All internal registers cleared.
- Reset mid-operation aborts the current candidate immediately with no result produced. Reset has priority over every other input.
- Internal registers:
  - n_reg (nbits)
  - d (nbits)
  - dsq (nbits+2, holds d*d, no overflow possible)
  - rem (nbits+1)
  - bitcnt (ceil log2 nbits)
- FSM states: IDLE, CHECK, DIV, TEST, DONE.
- IDLE:
  - in_rdy=1.
  - On in_val&&in_rdy: latch n_reg=in_num, clear iters, go to CHECK.
  - in_rdy is 0 in every other state.
- CHECK (1 cycle):
  - n<2: is_prime=0, factor=0, go to DONE.
  - n==2 or n==3: is_prime=1, factor=n, go to DONE.
  - Otherwise: d=2, dsq=4, rem=0, bitcnt=0, go to DIV.
- DIV (exactly nbits cycles):
  - Each cycle: t={rem[nbits-1:0], n_reg[nbits-1-bitcnt]}; rem = (t>=d) ? t-d : t.
  - Bits are consumed MSB first.
  - After the last bit, go to TEST.
- TEST (1 cycle):
  - Increment iters (saturating, not wrapping).
  - If rem==0: is_prime=0, factor=d, go to DONE.
  - Otherwise advance the divisor:
    - If d==2: d=3, dsq=9.
    - Else: d=d+2, dsq=dsq+4*d_old+4.
  - If the new dsq > n_reg: is_prime=1, factor=n_reg, go to DONE.
  - Otherwise clear rem and bitcnt, go to DIV.
- DONE:
  - out_val=1.
  - is_prime, factor and iters are held stable while out_rdy=0 (backpressure, any duration).
  - On out_rdy: go to IDLE next cycle. out_val drops; outputs keep their last values until the next candidate's CHECK/TEST update.
- Latency:
  - Counted from the accepting edge to the first cycle with out_val=1: 1 + k*(nbits+1) cycles, where k is the final iters.
  - For n<4 the latency is 1 cycle and iters=0.
- Handshakes:
  - in_val is ignored outside IDLE.
  - in_num is sampled only on the accepting edge; later changes to it have no effect.
  - Back-to-back operation: the earliest next acceptance is the cycle after out_val&&out_rdy.
- Boundary cases:
  - n=2^nbits-1 must terminate correctly; dsq never overflows nbits+2.
  - n equal to the square of a prime (e.g. 9, 25, 49) is detected composite because the loop continues while dsq <= n, which includes dsq == n.

Test Plan (nbits=8):
- reset, then in_num=1 -> out_val 1 cycle after acceptance; is_prime=0, factor=0, iters=0.
- in_num=4 -> out_val after 10 cycles; is_prime=0, factor=2, iters=1.
- in_num=9 -> out_val after 19 cycles; is_prime=0, factor=3, iters=2.
- in_num=251 -> out_val after 73 cycles; is_prime=1, factor=251, iters=8.
- in_num=255, out_rdy held low 5 cycles -> out_val stays 1 with factor=3 stable, in_rdy=0; then out_rdy=1 -> IDLE. A new in_num=13 is accepted next -> is_prime=1, iters=2.
- in_num=251 with reset pulsed during DIV -> next cycle in_rdy=1, out_val=0, all outputs 0. A subsequent in_num=2 -> is_prime=1, factor=2.
